// File: rtl/audio_mix_engine.sv
// rtl/audio_mix_engine.sv - time-multiplexed N-channel stereo mixer with per-channel volume and routing
// Optional feature macro: AUDIO_MIX_RAMP_EN (effective volume steps by 1 per accepted strobe toward target)
module audio_mix_engine #(
    parameter int NCH = 4,
    parameter int IW  = 10,
    parameter int OW  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_stb,
    input  logic [NCH*IW-1:0] ch_data,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [7:0]        cfg_din,
    output logic [7:0]        cfg_dout,
    input  logic              ovr_clr,
    output logic [OW-1:0]     audio_l,
    output logic [OW-1:0]     audio_r,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int AW   = IW + 6 + $clog2(NCH) + 1;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SH   = OW - IW;
    localparam int W2   = AW + SH;
    localparam logic signed [W2-1:0] OMAX = W2'((1 << (OW - 1)) - 1);
    localparam logic signed [W2-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic [NCH*IW-1:0]         samp_q, samp_d;
    logic [NCH-1:0][7:0]       cfg_q, cfg_d;
    logic [NCH-1:0][5:0]       vol_q, vol_d;
    logic [NCH-1:0]            rl_q, rl_d;
    logic [NCH-1:0]            rr_q, rr_d;
    logic signed [AW-1:0]      acc_l_q, acc_l_d;
    logic signed [AW-1:0]      acc_r_q, acc_r_d;
    logic [OW-1:0]             audio_l_q, audio_l_d;
    logic [OW-1:0]             audio_r_q, audio_r_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    logic [IW-1:0]             cur_u;
    logic [5:0]                cur_vol;
    logic                      cur_rl;
    logic                      cur_rr;
    logic signed [IW-1:0]      cur_s;
    logic signed [AW-1:0]      s_ext;
    logic signed [AW-1:0]      vol_ext;
    logic signed [AW-1:0]      prod;

    // Divide by 32 (unity gain), scale up to output width, clamp to the signed output range.
    function automatic logic [OW-1:0] sat_out(input logic signed [AW-1:0] a);
        logic signed [W2-1:0] v;
        v = (W2'(a) >>> 5) <<< SH;
        if (v > OMAX) return OMAX[OW-1:0];
        if (v < OMIN) return OMIN[OW-1:0];
        return v[OW-1:0];
    endfunction

`ifdef AUDIO_MIX_RAMP_EN
    // One step toward the programmed target so fades happen over many samples.
    function automatic logic [5:0] ramp_step(input logic [5:0] cur, input logic [5:0] tgt);
        if (cur < tgt) return cur + 6'd1;
        if (cur > tgt) return cur - 6'd1;
        return cur;
    endfunction
`endif

    // Config readback: unimplemented channel addresses read as zero.
    always_comb begin
        cfg_dout = 8'h00;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_addr == 4'(k)) cfg_dout = cfg_q[k];
        end
    end

    // Select the channel being accumulated this cycle and form its signed, scaled product.
    always_comb begin
        cur_u   = samp_q[IW-1:0];
        cur_vol = vol_q[0];
        cur_rl  = rl_q[0];
        cur_rr  = rr_q[0];
        for (int k = 1; k < NCH; k++) begin
            if (idx_q == IDXW'(k)) begin
                cur_u   = samp_q[k*IW +: IW];
                cur_vol = vol_q[k];
                cur_rl  = rl_q[k];
                cur_rr  = rr_q[k];
            end
        end
        // Flipping the MSB removes the midscale offset.
        cur_s   = $signed({~cur_u[IW-1], cur_u[IW-2:0]});
        s_ext   = AW'(cur_s);
        vol_ext = AW'({1'b0, cur_vol});
        prod    = s_ext * vol_ext;
    end

    // Next-state logic for the mix sequencer, config registers and status flags.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        samp_d      = samp_q;
        cfg_d       = cfg_q;
        vol_d       = vol_q;
        rl_d        = rl_q;
        rr_d        = rr_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        audio_l_d   = audio_l_q;
        audio_r_d   = audio_r_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (cfg_we) begin
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr == 4'(k)) cfg_d[k] = cfg_din;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sample_stb) begin
                    samp_d = ch_data;
                    // Shadow copy: cfg writes after this point cannot disturb the mix.
                    for (int k = 0; k < NCH; k++) begin
                        rl_d[k] = cfg_q[k][6];
                        rr_d[k] = cfg_q[k][7];
`ifdef AUDIO_MIX_RAMP_EN
                        vol_d[k] = ramp_step(vol_q[k], cfg_q[k][5:0]);
`else
                        vol_d[k] = cfg_q[k][5:0];
`endif
                    end
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (cur_rl) acc_l_d = acc_l_q + prod;
                if (cur_rr) acc_r_d = acc_r_q + prod;
                if (idx_q == IDXW'(NCH - 1)) state_d = S_OUT;
                else                          idx_d   = idx_q + IDXW'(1);
            end
            S_OUT: begin
                audio_l_d   = sat_out(acc_l_q);
                audio_r_d   = sat_out(acc_r_q);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe while busy is dropped; its set beats a same-cycle clear.
        if (ovr_clr) overrun_d = 1'b0;
        if (sample_stb && (state_q != S_IDLE)) overrun_d = 1'b1;

        busy_d = (state_d != S_IDLE);
    end

    // State registers; reset aborts any mix in flight and restores unity/L+R config.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            samp_q      <= '0;
            cfg_q       <= {NCH{8'hE0}};
            vol_q       <= {NCH{6'd32}};
            rl_q        <= '1;
            rr_q        <= '1;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            samp_q      <= samp_d;
            cfg_q       <= cfg_d;
            vol_q       <= vol_d;
            rl_q        <= rl_d;
            rr_q        <= rr_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign audio_l   = audio_l_q;
    assign audio_r   = audio_r_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mix_engine.sv
// tb/tb_audio_mix_engine.sv - scoreboard bench for audio_mix_engine with a behavioural mixing model
module tb_audio_mix_engine;

    localparam int NCH = 4;
    localparam int IW  = 10;
    localparam int OW  = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sample_stb;
    logic [NCH*IW-1:0] ch_data;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [7:0]        cfg_din;
    logic [7:0]        cfg_dout;
    logic              ovr_clr;
    logic [OW-1:0]     audio_l;
    logic [OW-1:0]     audio_r;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    audio_mix_engine #(.NCH(NCH), .IW(IW), .OW(OW)) dut (
        .clk(clk), .reset_n(reset_n), .sample_stb(sample_stb), .ch_data(ch_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
        .ovr_clr(ovr_clr), .audio_l(audio_l), .audio_r(audio_r),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] l;
        logic [OW-1:0] r;
        int            due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cfg_m[NCH];
    int   vol_m[NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [OW-1:0] model_sat(input int acc);
        int v;
        v = (acc >>> 5) * (1 << (OW - IW));
        if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
        if (v < -(1 << (OW - 1)))    v = -(1 << (OW - 1));
        return v[OW-1:0];
    endfunction

    // Reference mix: gain = vol/32 applied to midscale-removed samples, summed per routed side.
    task automatic model_mix(input logic [NCH*IW-1:0] d, output logic [OW-1:0] l, output logic [OW-1:0] r);
        int al, ar, s, tgt;
        al = 0;
        ar = 0;
        for (int k = 0; k < NCH; k++) begin
            tgt = cfg_m[k] % 64;
`ifdef AUDIO_MIX_RAMP_EN
            if (vol_m[k] < tgt) vol_m[k]++;
            else if (vol_m[k] > tgt) vol_m[k]--;
`else
            vol_m[k] = tgt;
`endif
            s = int'(d[k*IW +: IW]) - (1 << (IW - 1));
            if ((cfg_m[k] / 64) % 2 == 1) al += s * vol_m[k];
            if ((cfg_m[k] / 128) % 2 == 1) ar += s * vol_m[k];
        end
        l = model_sat(al);
        r = model_sat(ar);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            cfg_m[k] = 'hE0;
            vol_m[k] = 32;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic cfg_write(input int addr, input logic [7:0] din);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_din  = din;
        tick();
        cfg_we = 1'b0;
        if (addr < NCH) cfg_m[addr] = int'(din);
    endtask

    // Issue one accepted strobe; directed cases may supply hand-derived expected values.
    task automatic issue(input logic [NCH*IW-1:0] d, input bit use_c,
                         input logic [OW-1:0] cl, input logic [OW-1:0] cr);
        exp_t e;
        logic [OW-1:0] ml, mr;
        wait_idle();
        model_mix(d, ml, mr);
`ifdef AUDIO_MIX_RAMP_EN
        use_c = 1'b0;
`endif
        e.l = use_c ? cl : ml;
        e.r = use_c ? cr : mr;
        sample_stb = 1'b1;
        ch_data    = d;
        tick();
        sample_stb = 1'b0;
        e.due = cyc + 6;
        sbq.push_back(e);
    endtask

    function automatic logic [NCH*IW-1:0] rand_data();
        logic [NCH*IW-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*IW +: IW] = IW'($urandom);
        return d;
    endfunction

    // Monitor: every output pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (reset_n && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("audio_l", 32'(audio_l), 32'(e.l));
                chk("audio_r", 32'(audio_r), 32'(e.r));
                chk("latency", cyc, e.due);
            end
        end
    end

    initial begin
        logic [NCH*IW-1:0] d;
        int a, n;
        reset_n = 1'b0; sample_stb = 1'b0; ch_data = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_din = '0; ovr_clr = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_audio_l", 32'(audio_l), 0);
        chk("rst_audio_r", 32'(audio_r), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < NCH; k++) begin
            cfg_addr = 4'(k);
            #1 chk("rst_cfg_dout", cfg_dout, 8'hE0);
        end
        cfg_addr = 4'd9;
        #1 chk("cfg_dout_oob", cfg_dout, 8'h00);

        // Unity gain, single offset channel
        issue({10'h200, 10'h200, 10'h200, 10'h300}, 1'b1, 15'h2000, 15'h2000);
        chk("busy_in_mix", busy, 1);

        // Routing and mute
        cfg_write(0, 8'h60);
        cfg_write(1, 8'h00);
        cfg_write(12, 8'h3F);
        issue({10'h200, 10'h200, 10'h3FF, 10'h100}, 1'b1, 15'h6000, 15'h0000);
        cfg_write(0, 8'hE0);
        cfg_write(1, 8'hE0);

        // Saturation both ways
        for (int k = 0; k < NCH; k++) cfg_write(k, 8'hFF);
        issue({NCH{10'h3FF}}, 1'b1, 15'h3FFF, 15'h3FFF);
        issue({NCH{10'h000}}, 1'b1, 15'h4000, 15'h4000);
        for (int k = 0; k < NCH; k++) cfg_write(k, 8'hE0);

        // Overrun: second strobe two clocks in is ignored; set beats a same-cycle clear
        issue(rand_data(), 1'b0, '0, '0);
        tick();
        sample_stb = 1'b1; ch_data = rand_data();
        tick();
        sample_stb = 1'b0;
        chk("overrun_set", overrun, 1);
        sample_stb = 1'b1; ovr_clr = 1'b1;
        tick();
        sample_stb = 1'b0; ovr_clr = 1'b0;
        chk("overrun_set_wins", overrun, 1);
        wait_idle();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("overrun_clr", overrun, 0);

        // Config write during a mix only affects the next mix
        issue({10'h200, 10'h200, 10'h200, 10'h300}, 1'b1, 15'h2000, 15'h2000);
        cfg_write(0, 8'hC0);
        issue({10'h200, 10'h200, 10'h200, 10'h300}, 1'b1, 15'h0000, 15'h0000);
        cfg_write(0, 8'hE0);

        // Reset mid-mix: aborted with no output pulse
        issue(rand_data(), 1'b0, '0, '0);
        tick();
        reset_n = 1'b0;
        sbq.delete();
        model_reset();
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_audio_l", 32'(audio_l), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Randomized config and samples
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) cfg_write($urandom_range(0, 5), 8'($urandom));
            a = $urandom_range(0, 7);
            cfg_addr = 4'(a);
            #1 chk("cfg_dout_rand", cfg_dout, (a < NCH) ? 8'(cfg_m[a]) : 8'h00);
            d = rand_data();
            issue(d, 1'b0, '0, '0);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) tick();
        end

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain", sbq.size(), 0);
        chk("final_overrun", overrun, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
